// File: rtl/bit_scan_seq_if.sv
// bit_scan_seq_if: handshake bundle for the set-bit scanner.
//
// Handshake rules (both channels): a beat transfers on a rising clock edge
// where valid and ready are both 1. A producer holding valid keeps its payload
// stable until the transfer. Ready may depend combinationally on the other
// channel only as documented in bit_scan_seq (final-beat reload).
//
// Signals:
//   in_valid_i / in_ready_o / in_i   input word channel
//   out_valid_o / out_ready_i        output beat channel
//   idx_o, last_o, none_o            beat payload
//   count_o                          popcount of the word (BIT_SCAN_COUNT_EN only)
// Modports: master = producer/consumer side (testbench), slave = scanner.
interface bit_scan_seq_if #(
  parameter int GATE_WIDTH = 64
);
  localparam int IDX_W = $clog2(GATE_WIDTH);

  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [GATE_WIDTH-1:0] in_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [IDX_W-1:0]      idx_o;
  logic                  last_o;
  logic                  none_o;
`ifdef BIT_SCAN_COUNT_EN
  logic [IDX_W:0]        count_o;
`endif

  modport master (
`ifdef BIT_SCAN_COUNT_EN
    input  count_o,
`endif
    output in_valid_i,
    output in_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  idx_o,
    input  last_o,
    input  none_o
  );

  modport slave (
`ifdef BIT_SCAN_COUNT_EN
    output count_o,
`endif
    input  in_valid_i,
    input  in_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output idx_o,
    output last_o,
    output none_o
  );
endinterface

// File: rtl/bit_scan_seq.sv
// bit_scan_seq: sequential set-bit scanner.
//
// Accepts one GATE_WIDTH-bit word and emits the index of every set bit,
// lowest first, one index per output beat. An all-zeros word yields a single
// beat with none_o=1, last_o=1, idx_o=0.
//
// Ports:
//   clk_i      rising-edge clock
//   reset_i    asynchronous active-high reset
//   bus        bit_scan_seq_if.slave (input word channel, output beat channel)
//   dbg_state  current FSM state (0 = IDLE, 1 = SCAN)
//
// Optional feature macro: BIT_SCAN_COUNT_EN adds bus.count_o, the popcount of
// the accepted word, registered at the input handshake.
//
// Valid/ready: a transfer happens on a rising edge with valid & ready. in_ready
// is 1 in IDLE, and in SCAN only on the cycle the final beat is accepted
// (out_valid & last & out_ready); that is the sole combinational path from
// out_ready_i to in_ready_o and gives gap-free back-to-back words.
module bit_scan_seq #(
  parameter int GATE_WIDTH = 64
) (
  input  logic            clk_i,
  input  logic            reset_i,
  bit_scan_seq_if.slave   bus,
  output logic            dbg_state
);
  localparam int IDX_W = $clog2(GATE_WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [GATE_WIDTH-1:0] rem_q;
  logic                  zero_word_q;
  logic [GATE_WIDTH-1:0] rem_next;
  logic [IDX_W-1:0]      idx;
  logic                  last;
  logic                  in_ready;
  logic                  out_valid;
  logic                  load;
  logic                  pop;

  // Clearing the lowest set bit; zero result means at most one bit remained.
  assign rem_next = rem_q & (rem_q - GATE_WIDTH'(1));
  assign last     = ~|rem_next;

  // Lowest set bit wins: scan from the top so lower indices overwrite.
  always_comb begin
    idx = '0;
    for (int i = GATE_WIDTH - 1; i >= 0; i--) begin
      if (rem_q[i]) idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid_i) begin
          load    = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        if (bus.out_ready_i) begin
          pop = 1'b1;
          if (last) begin
            in_ready = 1'b1;
            if (bus.in_valid_i) begin
              load    = 1'b1;
              state_d = SCAN;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      zero_word_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // A reload on the final-beat cycle takes priority over the pop.
      if (load) begin
        rem_q       <= bus.in_i;
        zero_word_q <= ~|bus.in_i;
      end else if (pop) begin
        rem_q <= rem_next;
      end
    end
  end

`ifdef BIT_SCAN_COUNT_EN
  logic [IDX_W:0] popcount;
  logic [IDX_W:0] count_q;

  always_comb begin
    popcount = '0;
    for (int i = 0; i < GATE_WIDTH; i++) begin
      popcount = popcount + (IDX_W + 1)'(bus.in_i[i]);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= popcount;
    end
  end

  assign bus.count_o = count_q;
`endif

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.idx_o       = idx;
  assign bus.last_o      = last;
  assign bus.none_o      = zero_word_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_bit_scan_seq.sv
module tb_bit_scan_seq;
  localparam int GW = 64;
  localparam int IW = 6;
  localparam int EW = IW + 2;

  logic clk_i;
  logic reset_i;
  logic dbg_state;

  bit_scan_seq_if #(.GATE_WIDTH(GW)) bus ();

  bit_scan_seq #(.GATE_WIDTH(GW)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Expected beats, packed as {none, last, idx}, plus expected popcount per beat.
  logic [EW-1:0] exp_q[$];
  int            cnt_q[$];

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  // Expected beat list for a word: every set position ascending, the last one
  // flagged; an empty word gives one "none" beat.
  function automatic void push_word(input logic [GW-1:0] w);
    int n = 0;
    int seen = 0;
    logic [IW-1:0] ix;
    for (int i = 0; i < GW; i++) if (w[i]) n++;
    if (n == 0) begin
      exp_q.push_back({1'b1, 1'b1, {IW{1'b0}}});
      cnt_q.push_back(0);
    end else begin
      for (int i = 0; i < GW; i++) begin
        if (w[i]) begin
          seen++;
          ix = IW'(i);
          exp_q.push_back({1'b0, (seen == n), ix});
          cnt_q.push_back(n);
        end
      end
    end
  endfunction

  function automatic logic [GW-1:0] rand_word();
    logic [GW-1:0] w;
    int mode;
    w = {$urandom(), $urandom()};
    mode = $urandom_range(0, 4);
    case (mode)
      0: w = '0;
      1: w = w & {$urandom(), $urandom()} & {$urandom(), $urandom()};
      2: w = GW'(1) << $urandom_range(0, GW - 1);
      default: ;
    endcase
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.in_valid_i  = 1'b0;
    bus.in_i        = {$urandom(), $urandom()};
    bus.out_ready_i = 1'b0;
  endtask

  // Present one word from IDLE, drain it with random stalls, checking every beat.
  task automatic scan_word(input logic [GW-1:0] w, input int stall_pct, output int beats_cycles);
    logic [EW-1:0] e;
    int guard;
    beats_cycles = 0;
    @(negedge clk_i);
    bus.in_valid_i  = 1'b1;
    bus.in_i        = w;
    bus.out_ready_i = 1'b0;
    #1;
    checks++;
    if (bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL scan_word_accept: in_ready=%b required 1", bus.in_ready_o);
    end
    push_word(w);
    guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      guard++;
      @(negedge clk_i);
      bus.in_valid_i  = 1'b0;
      bus.in_i        = {$urandom(), $urandom()};
      bus.out_ready_i = ($urandom_range(0, 99) >= stall_pct);
      #1;
      e = exp_q[0];
      checks++;
      if (bus.out_valid_o !== 1'b1 || bus.idx_o !== e[IW-1:0] || bus.last_o !== e[IW] ||
          bus.none_o !== e[IW+1]) begin
        errors++;
        $display("FAIL scan_beat: valid=%b idx=%0d last=%b none=%b required valid=1 idx=%0d last=%b none=%b",
                 bus.out_valid_o, bus.idx_o, bus.last_o, bus.none_o, e[IW-1:0], e[IW], e[IW+1]);
      end
      checks++;
      if (bus.in_ready_o !== (bus.out_ready_i & e[IW])) begin
        errors++;
        $display("FAIL scan_in_ready: in_ready=%b required %b", bus.in_ready_o, bus.out_ready_i & e[IW]);
      end
`ifdef BIT_SCAN_COUNT_EN
      checks++;
      if (int'(bus.count_o) != cnt_q[0]) begin
        errors++;
        $display("FAIL scan_count: count=%0d required %0d", bus.count_o, cnt_q[0]);
      end
`endif
      beats_cycles++;
      if (bus.out_ready_i) begin
        void'(exp_q.pop_front());
        void'(cnt_q.pop_front());
      end
    end
    if (guard >= 2000) begin
      errors++;
      $display("FAIL scan_timeout: %0d beats outstanding required 0", exp_q.size());
      exp_q.delete();
      cnt_q.delete();
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL scan_return_idle: out_valid=%b in_ready=%b state=%b required 0 1 0",
               bus.out_valid_o, bus.in_ready_o, dbg_state);
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset_i = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.idx_o !== '0 ||
        bus.last_o !== 1'b1 || bus.none_o !== 1'b0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b idx=%0d last=%b none=%b state=%b required 1 0 0 1 0 0",
               bus.in_ready_o, bus.out_valid_o, bus.idx_o, bus.last_o, bus.none_o, dbg_state);
    end
`ifdef BIT_SCAN_COUNT_EN
    checks++;
    if (bus.count_o !== '0) begin
      errors++;
      $display("FAIL reset_count: count=%0d required 0", bus.count_o);
    end
`endif
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  task automatic test_sparse();
    int cyc;
    scan_word(64'h8000_0000_0000_0011, 0, cyc);
    checks++;
    if (cyc != 3) begin
      errors++;
      $display("FAIL sparse_cycles: cycles=%0d required 3", cyc);
    end
  endtask

  task automatic test_zero();
    int cyc;
    scan_word('0, 0, cyc);
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL zero_cycles: cycles=%0d required 1", cyc);
    end
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] want [3];
    want[0] = 6'd1; want[1] = 6'd2; want[2] = 6'd8;
    @(negedge clk_i);
    bus.in_valid_i = 1'b1;
    bus.in_i       = 64'h0000_0000_0000_0106;
    @(negedge clk_i);
    bus.in_valid_i = 1'b0;
    bus.in_i       = '1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk_i);
      bus.out_ready_i = 1'b0;
      #1;
      checks++;
      if (bus.out_valid_o !== 1'b1 || bus.idx_o !== 6'd1 || bus.last_o !== 1'b0 || bus.in_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: cycle=%0d valid=%b idx=%0d last=%b in_ready=%b required 1 1 0 0",
                 c, bus.out_valid_o, bus.idx_o, bus.last_o, bus.in_ready_o);
      end
    end
    for (int b = 0; b < 3; b++) begin
      @(negedge clk_i);
      bus.out_ready_i = 1'b1;
      #1;
      checks++;
      if (bus.out_valid_o !== 1'b1 || bus.idx_o !== want[b] || bus.last_o !== (b == 2)) begin
        errors++;
        $display("FAIL bp_beat: beat=%0d valid=%b idx=%0d last=%b required 1 %0d %b",
                 b, bus.out_valid_o, bus.idx_o, bus.last_o, want[b], (b == 2));
      end
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_extra_beat: out_valid=%b required 0", bus.out_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i);
    bus.in_valid_i = 1'b1;
    bus.in_i       = 64'h1;
    @(negedge clk_i);
    bus.in_i        = 64'h2;
    bus.out_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.idx_o !== 6'd0 || bus.last_o !== 1'b1 || bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: valid=%b idx=%0d last=%b in_ready=%b required 1 0 1 1",
               bus.out_valid_o, bus.idx_o, bus.last_o, bus.in_ready_o);
    end
    @(negedge clk_i);
    bus.in_valid_i = 1'b0;
    bus.in_i       = '0;
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.idx_o !== 6'd1 || bus.last_o !== 1'b1 || bus.none_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: valid=%b idx=%0d last=%b none=%b required 1 1 1 0",
               bus.out_valid_o, bus.idx_o, bus.last_o, bus.none_o);
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: out_valid=%b in_ready=%b required 0 1", bus.out_valid_o, bus.in_ready_o);
    end
  endtask

  task automatic test_all_ones();
    int cyc;
    scan_word('1, 0, cyc);
    checks++;
    if (cyc != GW) begin
      errors++;
      $display("FAIL ones_cycles: cycles=%0d required %0d", cyc, GW);
    end
  endtask

  task automatic test_reset_mid_scan();
    int cyc;
    @(negedge clk_i);
    bus.in_valid_i = 1'b1;
    bus.in_i       = 64'hF0;
    @(negedge clk_i);
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.idx_o !== 6'd4) begin
      errors++;
      $display("FAIL rst_mid_first: valid=%b idx=%0d required 1 4", bus.out_valid_o, bus.idx_o);
    end
    @(negedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.idx_o !== '0 ||
        bus.last_o !== 1'b1 || bus.none_o !== 1'b0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_values: in_ready=%b out_valid=%b idx=%0d last=%b none=%b state=%b required 1 0 0 1 0 0",
               bus.in_ready_o, bus.out_valid_o, bus.idx_o, bus.last_o, bus.none_o, dbg_state);
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      #1;
      checks++;
      if (bus.out_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_stale_beat: cycle=%0d out_valid=%b required 0", c, bus.out_valid_o);
      end
    end
    idle_inputs();
    scan_word(64'h1, 0, cyc);
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL rst_mid_new_word: cycles=%0d required 1", cyc);
    end
  endtask

  // Free-running producer/consumer: the model says the block is idle exactly when
  // no expected beats remain, and may reload when the only remaining beat leaves.
  task automatic test_random_stream();
    int words_left = 40;
    int guard = 0;
    logic [EW-1:0] e;
    logic exp_ready;
    idle_inputs();
    while ((words_left > 0 || bus.in_valid_i || exp_q.size() > 0) && guard < 8000) begin
      guard++;
      @(negedge clk_i);
      if (!bus.in_valid_i) begin
        if (words_left > 0 && $urandom_range(0, 99) < 60) begin
          bus.in_valid_i = 1'b1;
          bus.in_i       = rand_word();
          words_left--;
        end else begin
          bus.in_i = {$urandom(), $urandom()};
        end
      end
      bus.out_ready_i = ($urandom_range(0, 99) < 70);
      #1;
      exp_ready = (exp_q.size() == 0) || (bus.out_ready_i && exp_q.size() == 1);
      checks++;
      if (bus.in_ready_o !== exp_ready || bus.out_valid_o !== (exp_q.size() > 0)) begin
        errors++;
        $display("FAIL stream_flow: in_ready=%b out_valid=%b required %b %b",
                 bus.in_ready_o, bus.out_valid_o, exp_ready, (exp_q.size() > 0));
      end
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        checks++;
        if (bus.idx_o !== e[IW-1:0] || bus.last_o !== e[IW] || bus.none_o !== e[IW+1]) begin
          errors++;
          $display("FAIL stream_beat: idx=%0d last=%b none=%b required %0d %b %b",
                   bus.idx_o, bus.last_o, bus.none_o, e[IW-1:0], e[IW], e[IW+1]);
        end
`ifdef BIT_SCAN_COUNT_EN
        checks++;
        if (int'(bus.count_o) != cnt_q[0]) begin
          errors++;
          $display("FAIL stream_count: count=%0d required %0d", bus.count_o, cnt_q[0]);
        end
`endif
        if (bus.out_ready_i) begin
          void'(exp_q.pop_front());
          void'(cnt_q.pop_front());
        end
      end
      if (bus.in_valid_i && exp_ready) begin
        push_word(bus.in_i);
        @(posedge clk_i);
        #1;
        bus.in_valid_i = 1'b0;
      end
    end
    if (guard >= 8000) begin
      errors++;
      $display("FAIL stream_timeout: words_left=%0d beats_left=%0d required 0 0", words_left, exp_q.size());
    end
    @(negedge clk_i);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sparse();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_all_ones();
    test_reset_mid_scan();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bit_scan_seq.md
# bit_scan_seq

Sequential set-bit scanner: accepts one GATE_WIDTH-bit word over a valid/ready handshake and emits the index of every set bit, lowest first, one index per accepted output beat. It is the expanding counterpart of the OR_N reduction. Where OR_N collapses a vector into "any bit set", this block turns the vector back into the positions of its set bits. The datapath uses it for register-list walks (multi-register load/store sequencing) and for interrupt/flag priority scans.

## Interface
- GATE_WIDTH, 64, width of the scanned word; a power of two, at least 2.
- IDX_W, $clog2(GATE_WIDTH), index width; derived, never overridden.
- clk_i  input  1  single clock; all state is updated on the rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- in_valid_i  input  1  input word valid.
- in_ready_o  output  1  block can accept a word.
- in_i  input  GATE_WIDTH  word to scan; sampled only on an input handshake.
- out_valid_o  output  1  output beat valid.
- out_ready_i  input  1  consumer accepts the beat.
- idx_o  output  IDX_W  index of the lowest remaining set bit.
- last_o  output  1  this beat is the final beat for the current word.
- none_o  output  1  the accepted word was all zeros; idx_o is 0 on that beat.
- count_o  output  IDX_W+1  popcount of the accepted word; present only with BIT_SCAN_COUNT_EN.

## Operation
- Two states: IDLE and SCAN. Internal registers:
  - rem: the remaining word, GATE_WIDTH bits.
  - zero_word: 1 bit, marks an all-zeros input.
- IDLE:
  - in_ready_o is 1 and out_valid_o is 0.
  - An input handshake (in_valid_i & in_ready_o) loads rem <= in_i and zero_word <= ~|in_i, then moves to SCAN.
- SCAN:
  - out_valid_o is 1.
  - idx_o is the priority encode of the lowest set bit of rem. It is 0 when rem is zero.
  - none_o equals zero_word.
  - last_o is 1 when rem has at most one set bit. Compute it as ~|(rem & (rem - 1)).
- On an output handshake (out_valid_o & out_ready_i):
  - rem <= rem & (rem - 1), which clears the lowest set bit.
  - If last_o is 1, go to IDLE.
- Back-to-back words:
  - in_ready_o is also 1 during SCAN on the cycle of the final beat's handshake: out_valid_o & last_o & out_ready_i.
  - A word accepted on that cycle reloads rem and the state stays SCAN, so there is no bubble.
  - This is the only combinational path from out_ready_i to in_ready_o.
- An all-zeros word produces exactly one beat with none_o=1, last_o=1, idx_o=0.
- Outputs (idx_o, last_o, none_o) hold stable while out_valid_o=1 and out_ready_i=0.
- in_i is ignored outside a handshake.
- in_valid_i during SCAN, other than on the final-beat cycle, is not accepted. The producer must hold it.

## Timing
- Reset, asynchronous, applies immediately:
  - State goes to IDLE; rem and zero_word clear to 0.
  - Outputs: in_ready_o=1, out_valid_o=0, idx_o=0, last_o=1, none_o=0, count_o=0.
- Reset asserted mid-SCAN discards the word; no further beats are emitted for it.
- First beat latency: out_valid_o is high on the cycle after the input handshake.
- Throughput with out_ready_i held high: max(popcount, 1) cycles per word. A full word of GATE_WIDTH ones takes GATE_WIDTH cycles.
- idx_o, last_o and none_o are combinational from registered rem and zero_word only; there is no path from in_i.

## Configuration
- BIT_SCAN_COUNT_EN defined:
  - count_o exists and is registered at the input handshake with the popcount of in_i.
  - It holds on every beat of that word.
  - It reads 0 for an all-zeros word and GATE_WIDTH for an all-ones word.
- BIT_SCAN_COUNT_EN undefined: count_o and the popcount logic are absent. All other behaviour is identical.

## Test plan
- Sparse word: in_i=64'h8000_0000_0000_0011, out_ready_i held 1.
  - Beats: idx 0, 4, 63, with last_o=1 only on idx 63.
  - in_ready_o=0 for the intervening cycles; count_o=3 when the macro is enabled.
- Zero word: in_i=0.
  - One beat: none_o=1, last_o=1, idx_o=0.
  - Next cycle: in_ready_o=1 and out_valid_o=0.
- Backpressure: in_i=64'h0000_0000_0000_0106, out_ready_i=0 for 5 cycles.
  - idx_o=1 is held stable for those 5 cycles.
  - Then beats idx 1, 2, 8 with no duplicates or drops.
- Back-to-back: word 64'h1, then 64'h2 presented on the final-beat cycle.
  - The second word is accepted on that cycle.
  - Beats: idx 0 (last), then idx 1 (last) on consecutive cycles.
- All ones: in_i=64'hFFFF_FFFF_FFFF_FFFF.
  - 64 consecutive beats, idx 0..63 ascending, last_o only on 63.
- Reset mid-scan: with in_i=64'hF0 loaded, assert reset_i after the idx 4 beat.
  - Outputs take their reset values immediately and no further beats appear.
  - A new word 64'h1 then yields a single idx 0 beat.
